// File: rtl/processador_led_fader.sv
// processador_led_fader: soft-fade PWM driver between the LED PIO and the board pins.
// Define LED_FADER_FADE_EN to enable the prescaled ramp; otherwise duty snaps straight to the target.
module processador_led_fader #(
    parameter int NUM_LEDS   = 4,
    parameter int DUTY_W     = 8,
    parameter int PRESCALE   = 50000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam logic [DUTY_W-1:0]   DMAX     = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0]   DZERO    = {DUTY_W{1'b0}};
    localparam logic [DUTY_W-1:0]   DONE     = DUTY_W'(1'b1);
    localparam logic                POL      = (ACTIVE_LOW != 0);
    localparam logic [NUM_LEDS-1:0] POL_MASK = {NUM_LEDS{POL}};

    logic [NUM_LEDS-1:0] tgt_r;
    logic [NUM_LEDS-1:0] lit_s;
    logic [NUM_LEDS-1:0] active_s;
    logic [NUM_LEDS-1:0] led_out_r;
    logic                busy_r;
    logic [DUTY_W-1:0]   pwm_cnt_r;
    logic [DUTY_W-1:0]   duty_r     [NUM_LEDS];
    logic [DUTY_W-1:0]   duty_nxt_s [NUM_LEDS];

    // Target capture and free-running PWM counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_r     <= {NUM_LEDS{1'b0}};
            pwm_cnt_r <= DZERO;
        end else begin
            tgt_r     <= led_in;
            pwm_cnt_r <= pwm_cnt_r + DONE;
        end
    end

`ifdef LED_FADER_FADE_EN
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt_r;
    logic            tick_s;

    // Shared fade-step prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt_r <= {PS_W{1'b0}};
        end else if (ps_cnt_r == PS_LAST) begin
            ps_cnt_r <= {PS_W{1'b0}};
        end else begin
            ps_cnt_r <= ps_cnt_r + PS_W'(1'b1);
        end
    end

    assign tick_s = (ps_cnt_r == PS_LAST);

    // Saturating ramp toward the captured target; direction is re-read every tick
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty_nxt_s[i] = duty_r[i];
            active_s[i]   = tgt_r[i] ? (duty_r[i] != DMAX) : (duty_r[i] != DZERO);
            if (tick_s && active_s[i]) begin
                if (tgt_r[i]) begin
                    duty_nxt_s[i] = duty_r[i] + DONE;
                end else begin
                    duty_nxt_s[i] = duty_r[i] - DONE;
                end
            end else begin
                duty_nxt_s[i] = duty_r[i];
            end
        end
    end
`else
    // Without fading the duty snaps to full on/off and no channel is ever in transit
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty_nxt_s[i] = DZERO;
            if (tgt_r[i]) begin
                duty_nxt_s[i] = DMAX;
            end else begin
                duty_nxt_s[i] = DZERO;
            end
        end
        active_s = {NUM_LEDS{1'b0}};
    end
`endif

    // Per-channel duty registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_r[i] <= DZERO;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_r[i] <= duty_nxt_s[i];
            end
        end
    end

    // PWM compare; full scale is forced solid on so it never blinks at the wrap
    always_comb begin
        lit_s = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            lit_s[i] = (duty_r[i] == DMAX) | (duty_r[i] > pwm_cnt_r);
        end
    end

    // Registered pin drive and busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_out_r <= POL_MASK;
            busy_r    <= 1'b0;
        end else begin
            led_out_r <= lit_s ^ POL_MASK;
            busy_r    <= |active_s;
        end
    end

    assign led_out = led_out_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_processador_led_fader.sv
// Directed bench for processador_led_fader; covers whichever build LED_FADER_FADE_EN selects.
module tb_processador_led_fader;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] led_in;
    logic [3:0] led_out, led_out_inv, led_out_slow;
    logic       busy, busy_inv, busy_slow;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int hi;
    int bad;

    always #5 clk = ~clk;

    processador_led_fader #(.NUM_LEDS(4), .DUTY_W(4), .PRESCALE(2), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .reset(reset), .led_in(led_in), .led_out(led_out), .busy(busy));

    processador_led_fader #(.NUM_LEDS(4), .DUTY_W(4), .PRESCALE(2), .ACTIVE_LOW(1)) u_inv (
        .clk(clk), .reset(reset), .led_in(led_in), .led_out(led_out_inv), .busy(busy_inv));

    // Slow ramp: each duty value is held for four whole PWM periods
    processador_led_fader #(.NUM_LEDS(4), .DUTY_W(4), .PRESCALE(64), .ACTIVE_LOW(0)) u_slow (
        .clk(clk), .reset(reset), .led_in(led_in), .led_out(led_out_slow), .busy(busy_slow));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_to(input int k);
        while (cyc < k) step();
    endtask

    // Pulse reset; cyc counts clock edges after release, led_in already at lin
    task automatic do_reset(input logic [3:0] lin);
        @(negedge clk);
        reset  = 1'b1;
        led_in = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        led_in = lin;
        reset  = 1'b0;
        cyc    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        led_in = 4'b0000;
        #1;
        chk("rst_led", led_out, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_led_inv", led_out_inv, 4'b1111);
        chk("rst_busy_inv", busy_inv, 1'b0);

        do_reset(4'b0000);
        bad = 0;
        repeat (100) begin
            step();
            bad += int'(led_out != 4'b0000 || busy || led_out_inv != 4'b1111);
        end
        chk("idle_100", bad, 0);

`ifdef LED_FADER_FADE_EN
        // Rise 0 -> 15 on channel 0: tick on even edges, duty m after edge 2m
        do_reset(4'b0001);
        step();
        chk("busy_lat1", busy, 1'b0);
        step();
        chk("busy_lat2", busy, 1'b1);
        while (busy && cyc < 100) step();
        chk("rise_done_cyc", cyc, 31);
        chk("rise_on_led", led_out, 4'b0001);
        chk("rise_on_inv", led_out_inv, 4'b1110);
        bad = 0;
        repeat (32) begin
            step();
            bad += int'(led_out != 4'b0001 || busy);
        end
        chk("on_steady", bad, 0);

        // Fall from 8 on channel 1: duty 8,8,7,7,...; PWM highs on samples 17..22
        do_reset(4'b0010);
        step_to(16);
        chk("fall_busy16", busy, 1'b1);
        led_in = 4'b0000;
        hi = 0;
        repeat (16) begin
            step();
            hi += int'(led_out[1]);
            if (cyc == 22) chk("fall_s22", led_out[1], 1'b1);
            if (cyc == 23) chk("fall_s23", led_out[1], 1'b0);
        end
        chk("fall_hi_cnt", hi, 6);
        chk("fall_busy32", busy, 1'b1);
        step();
        chk("fall_busy33", busy, 1'b0);
        chk("fall_led33", led_out, 4'b0000);

        // Slow instance: duty d after edge 64d, so a 16-sample window reads d highs
        do_reset(4'b0001);
        step_to(2);
        chk("slow_busy", busy_slow, 1'b1);
        step_to(128);
        hi = 0;
        repeat (16) begin step(); hi += int'(led_out_slow[0]); end
        chk("slow_d2", hi, 2);
        step_to(320);
        hi = 0;
        repeat (16) begin step(); hi += int'(led_out_slow[0]); end
        chk("slow_d5", hi, 5);
        step_to(384);
        led_in = 4'b0000;
        step_to(448);
        hi = 0;
        repeat (16) begin step(); hi += int'(led_out_slow[0]); end
        chk("slow_rev_d5", hi, 5);
        step_to(512);
        hi = 0;
        repeat (16) begin step(); hi += int'(led_out_slow[0]); end
        chk("slow_rev_d4", hi, 4);
        chk("slow_busy_fall", busy_slow, 1'b1);
        step_to(576);
        hi = 0;
        repeat (16) begin step(); hi += int'(led_out_slow[0]); end
        chk("slow_rev_d3", hi, 3);

        // Reset mid-fade at duty 10: pins dark at once, ramp restarts from zero
        do_reset(4'b1111);
        step_to(20);
        reset = 1'b1;
        #1;
        chk("midrst_led", led_out, 4'b0000);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_inv", led_out_inv, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        step_to(2);
        chk("restart_busy", busy, 1'b1);
        while (busy && cyc < 100) step();
        chk("restart_done_cyc", cyc, 31);
        chk("restart_led", led_out, 4'b1111);
`else
        // Direct path: capture, duty, output register -> three clocks
        do_reset(4'b0000);
        step_to(5);
        led_in = 4'b0101;
        step();
        chk("nf_lat1", led_out, 4'b0000);
        step();
        chk("nf_lat2", led_out, 4'b0000);
        step();
        chk("nf_lat3", led_out, 4'b0101);
        chk("nf_lat3_inv", led_out_inv, 4'b1010);
        chk("nf_lat3_slow", led_out_slow, 4'b0101);
        bad = 0;
        repeat (32) begin
            step();
            bad += int'(led_out != 4'b0101 || busy || busy_slow || led_out_slow != 4'b0101);
        end
        chk("nf_steady", bad, 0);
        led_in = 4'b1010;
        step();
        step();
        chk("nf_sw2", led_out, 4'b0101);
        step();
        chk("nf_sw3", led_out, 4'b1010);
        chk("nf_busy", busy, 1'b0);
        reset = 1'b1;
        #1;
        chk("nf_midrst_led", led_out, 4'b0000);
        chk("nf_midrst_inv", led_out_inv, 4'b1111);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        step();
        chk("nf_post1", led_out, 4'b0000);
        step();
        step();
        chk("nf_post3", led_out, 4'b1010);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
